// File: rtl/shift_chain_ctrl_if.sv
// Bundle between a word producer / serial consumer and shift_chain_ctrl.
//
// Handshake: the producer raises start with data_in/msb_first valid; the
// controller accepts on the first rising edge where it is idle (busy = 0)
// and start = 1. busy then stays high until the end of the done cycle.
// start seen while busy is dropped, never queued, so a producer that holds
// start high simply gets its next word accepted on the edge after done.
//
// Signals:
//   start      producer -> ctrl  request to serialize data_in
//   data_in    producer -> ctrl  parallel word, sampled on the accepting edge
//   msb_first  producer -> ctrl  bit order, sampled with data_in
//   ser_out    ctrl -> consumer  chain output stage
//   bit_tick   ctrl -> consumer  shift enable, last cycle of each bit period
//   busy       ctrl -> producer  word in flight (accept edge through done)
//   done       ctrl -> producer  one-cycle pulse after the last bit period
interface shift_chain_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] data_in;
  logic             msb_first;
  logic             ser_out;
  logic             bit_tick;
  logic             busy;
  logic             done;

  modport master (
    output start, data_in, msb_first,
    input  ser_out, bit_tick, busy, done
  );

  modport slave (
    input  start, data_in, msb_first,
    output ser_out, bit_tick, busy, done
  );
endinterface

// File: rtl/shift_chain_ctrl.sv
// Sequencer for a parallel-in/serial-out chain of clock-enabled DFFs.
// A start in IDLE loads the word (bit-reversed for LSB-first so the first
// bit always sits in the output stage), then a prescaler produces one
// bit_tick every DIV cycles; each tick shifts the chain toward the output.
// After WIDTH ticks a single DONE cycle reports completion.
//
// Ports:
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   bus        shift_chain_ctrl_if slave side (start/data_in/msb_first in,
//              ser_out/bit_tick/busy/done out)
//   state_dbg  current FSM state (0 IDLE, 1 SHIFT, 2 DONE)
//   order_dbg  latched bit order of the word in flight
module shift_chain_ctrl #(
  parameter int WIDTH = 8,
  parameter int DIV   = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  shift_chain_ctrl_if.slave    bus,
  output logic [1:0]           state_dbg,
  output logic                 order_dbg
);

  localparam int PW = ($clog2(DIV + 1) < 1) ? 1 : $clog2(DIV + 1);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] chain;
  logic [WIDTH-1:0] load_word;
  logic [PW-1:0]    presc;
  logic [CW-1:0]    bit_cnt;
  logic             busy_q;
  logic             done_q;
  logic             msb_q;
  logic             tick;

  // LSB-first words are reversed at load time so the shift direction
  // never changes.
  always_comb begin
    load_word = bus.data_in;
    if (!bus.msb_first) begin
      for (int i = 0; i < WIDTH; i++) begin
        load_word[i] = bus.data_in[WIDTH-1-i];
      end
    end
  end

  assign tick = (state == S_SHIFT) && (presc == PRESC_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      chain   <= '0;
      presc   <= '0;
      bit_cnt <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      msb_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            chain   <= load_word;
            msb_q   <= bus.msb_first;
            presc   <= '0;
            bit_cnt <= '0;
            busy_q  <= 1'b1;
            state   <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (tick) begin
            presc   <= '0;
            chain   <= {chain[WIDTH-2:0], 1'b0};
            bit_cnt <= bit_cnt + CW'(1);
            // bit_cnt counts ticks already taken; this is the WIDTH-th.
            if (bit_cnt == CNT_LAST) begin
              state  <= S_DONE;
              done_q <= 1'b1;
            end
          end else begin
            presc <= presc + PW'(1);
          end
        end
        S_DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          state  <= S_IDLE;
          done_q <= 1'b0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  // The chain is already empty after the last shift, but gating keeps
  // ser_out at 0 in DONE/IDLE regardless.
  assign bus.ser_out  = (state == S_SHIFT) & chain[WIDTH-1];
  assign bus.bit_tick = tick;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign state_dbg    = state;
  assign order_dbg    = msb_q;

endmodule

// File: tb/tb_shift_chain_ctrl.sv
module tb_shift_chain_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- DUTs ----------------
  shift_chain_ctrl_if #(.WIDTH(8)) if0 ();
  shift_chain_ctrl_if #(.WIDTH(4)) if1 ();
  logic [1:0] state_dbg0, state_dbg1;
  logic       order_dbg0, order_dbg1;

  shift_chain_ctrl #(.WIDTH(8), .DIV(4)) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(if0.slave),
    .state_dbg(state_dbg0), .order_dbg(order_dbg0)
  );

  shift_chain_ctrl #(.WIDTH(4), .DIV(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(if1.slave),
    .state_dbg(state_dbg1), .order_dbg(order_dbg1)
  );

  // ---------------- scoreboard ----------------
  int tests = 0;
  int fails = 0;
  logic [0:0] exp_q[$];
  logic [0:0] cur_bit;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_start0(input logic [7:0] data, input logic msb);
    if0.start     = 1'b1;
    if0.data_in   = data;
    if0.msb_first = msb;
  endtask

  // Called at the negedge where start is already up; the next posedge is
  // the accepting edge. seq holds the expected serial bits, seq[7] first.
  task automatic check_word(input string tag, input logic [7:0] seq, input logic exp_order,
                            input bit hold, input logic [7:0] next_data, input bit scramble);
    exp_q.delete();
    for (int i = 7; i >= 0; i--) exp_q.push_back(seq[i]);
    for (int cyc = 1; cyc <= 33; cyc++) begin
      @(negedge clk);
      if (cyc == 1 && !hold) if0.start = 1'b0;
      if (cyc == 2 && hold) if0.data_in = next_data;
      if (scramble && cyc == 10) begin
        if0.data_in   = 8'($urandom_range(0, 255));
        if0.msb_first = ~if0.msb_first;
      end
      check($sformatf("%s.busy c%0d", tag, cyc), 32'(if0.busy), 32'd1);
      if (cyc <= 32) begin
        if ((cyc - 1) % 4 == 0) cur_bit = exp_q.pop_front();
        check($sformatf("%s.ser c%0d", tag, cyc), 32'(if0.ser_out), 32'(cur_bit));
      end else begin
        check($sformatf("%s.ser c%0d", tag, cyc), 32'(if0.ser_out), 32'd0);
      end
      check($sformatf("%s.tick c%0d", tag, cyc), 32'(if0.bit_tick),
            32'((cyc % 4 == 0) && (cyc <= 32)));
      check($sformatf("%s.done c%0d", tag, cyc), 32'(if0.done), 32'(cyc == 33));
      if (cyc == 1 || cyc == 33)
        check($sformatf("%s.order c%0d", tag, cyc), 32'(order_dbg0), 32'(exp_order));
    end
    @(negedge clk);
    check({tag, ".gap_busy"}, 32'(if0.busy), 32'd0);
    check({tag, ".gap_done"}, 32'(if0.done), 32'd0);
    check({tag, ".gap_state"}, 32'(state_dbg0), 32'd0);
  endtask

  task automatic check_idle0(input string tag);
    check({tag, ".ser"},  32'(if0.ser_out),  32'd0);
    check({tag, ".tick"}, 32'(if0.bit_tick), 32'd0);
    check({tag, ".busy"}, 32'(if0.busy),     32'd0);
    check({tag, ".done"}, 32'(if0.done),     32'd0);
  endtask

  // ---------------- directed sequence ----------------
  logic [3:0] d1_ser;

  initial begin
    if0.start = 1'b0; if0.data_in = '0; if0.msb_first = 1'b1;
    if1.start = 1'b0; if1.data_in = '0; if1.msb_first = 1'b1;

    // Reset values
    repeat (2) @(negedge clk);
    check_idle0("rst");
    check("rst.state", 32'(state_dbg0), 32'd0);
    reset_n = 1'b1;

    // Idle: start low for 20 cycles
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check_idle0($sformatf("idle c%0d", c));
      check($sformatf("idle1.busy c%0d", c), 32'(if1.busy), 32'd0);
    end

    // MSB first 0xC1 -> 1,1,0,0,0,0,0,1
    drive_start0(8'hC1, 1'b1);
    check_word("msb_c1", 8'b1100_0001, 1'b1, 1'b0, 8'h00, 1'b0);

    // LSB first 0xC1 -> 1,0,0,0,0,0,1,1, inputs scrambled mid-word
    drive_start0(8'hC1, 1'b0);
    check_word("lsb_c1", 8'b1000_0011, 1'b0, 1'b0, 8'h00, 1'b1);

    // Start held high: 0xFF then 0x00, one idle cycle between
    drive_start0(8'hFF, 1'b1);
    check_word("b2b_w1", 8'b1111_1111, 1'b1, 1'b1, 8'h00, 1'b0);
    check_word("b2b_w2", 8'b0000_0000, 1'b1, 1'b0, 8'h00, 1'b0);

    // Reset in the 3rd bit period (0xE1: 3rd bit is 1), between edges
    drive_start0(8'hE1, 1'b1);
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clk);
      if (cyc == 1) if0.start = 1'b0;
    end
    check("pre_rst.ser",  32'(if0.ser_out),  32'd1);
    check("pre_rst.tick", 32'(if0.bit_tick), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_idle0("mid_rst");
    check("mid_rst.state", 32'(state_dbg0), 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("mid_rst.done c%0d", c), 32'(if0.done), 32'd0);
    end
    // Release and request on the same negedge: first posedge accepts
    reset_n = 1'b1;
    drive_start0(8'h81, 1'b1);
    check_word("post_rst_81", 8'b1000_0001, 1'b1, 1'b0, 8'h00, 1'b0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("post_rst.done c%0d", c), 32'(if0.done), 32'd0);
    end

    // DIV = 1, WIDTH = 4: 0xA MSB first -> 1,0,1,0 on consecutive cycles
    d1_ser = 4'b1010;
    if1.start = 1'b1; if1.data_in = 4'hA; if1.msb_first = 1'b1;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(negedge clk);
      if (cyc == 1) if1.start = 1'b0;
      check($sformatf("div1.ser c%0d", cyc), 32'(if1.ser_out),
            (cyc <= 4) ? 32'(d1_ser[4-cyc]) : 32'd0);
      check($sformatf("div1.tick c%0d", cyc), 32'(if1.bit_tick), 32'(cyc <= 4));
      check($sformatf("div1.busy c%0d", cyc), 32'(if1.busy), 32'(cyc <= 5));
      check($sformatf("div1.done c%0d", cyc), 32'(if1.done), 32'(cyc == 5));
    end

    // ---------------- final report ----------------
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/shift_chain_ctrl.md
# shift_chain_ctrl

Sequencing controller for a chain of clock-enabled D flip-flops used as a parallel-in/serial-out shift register. On a start request it loads a parallel word into the chain. It then generates a prescaled enable tick that shifts the chain one position per bit period, and reports completion with a busy/done handshake. It sits between a data producer (switches, FSM or counter) and a serial consumer (LED, PMOD pin, downstream logic) on the board-level clock.

## Interface
- WIDTH, 8: number of DFF stages in the chain and bits per word; legal range ≥ 2.
- DIV, 4: clock cycles per serial bit period; legal range ≥ 1.

- clk  input  1  system clock; all state changes on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  request to serialize data_in; sampled only in IDLE.
- data_in  input  WIDTH  parallel word; captured on the accepting edge.
- msb_first  input  1  bit order; 1 = MSB first, 0 = LSB first; captured with data_in.
- ser_out  output  1  current serial bit (chain output stage).
- bit_tick  output  1  shift enable driven to the chain; one-cycle pulse at the end of each bit period.
- busy  output  1  high from the accepting edge through the DONE cycle.
- done  output  1  one-cycle pulse after the last bit period.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE:
  - busy = 0, done = 0, bit_tick = 0, ser_out = 0.
  - On a rising edge with start = 1:
    - load data_in into the chain, applying bit reversal when msb_first = 0, so the first bit is always at the output stage;
    - latch msb_first;
    - clear the prescaler and the bit counter;
    - go to SHIFT.
- SHIFT:
  - The prescaler counts 0..DIV-1 and wraps.
  - bit_tick = 1 combinationally when the prescaler equals DIV-1; otherwise 0.
  - On each tick edge the chain shifts one stage toward the output, a zero fills the input end, and the bit counter increments.
  - On the edge of the WIDTH-th tick, go to DONE.
- DONE:
  - Lasts one cycle: done = 1, busy = 1, bit_tick = 0, ser_out = 0.
  - Next state is IDLE.
- start is ignored while in SHIFT or DONE; it is never queued.
- data_in and msb_first are don't-care outside the accepting edge.
- The prescaler is ceil(log2(DIV+1)) bits wide, with a minimum of 1.
- The bit counter is ceil(log2(WIDTH+1)) bits wide.
- Wrap happens exactly at DIV-1; the counters never overflow.

## Timing
- Accepting edge E0 (start = 1 in IDLE): busy and ser_out are valid (first bit) in the cycle after E0.
- Each bit k (k = 0..WIDTH-1) is held on ser_out for exactly DIV cycles.
- bit_tick is high in the last cycle of each bit period.
- done is high in cycle WIDTH*DIV + 1 after E0.
- busy is high for WIDTH*DIV + 1 cycles.
- The earliest next accept is the edge following the DONE cycle, so back-to-back words have a one-cycle IDLE gap.
- DIV = 1: bit_tick is high every SHIFT cycle, and each bit lasts one cycle.
- Reset asserted at any time, including mid-SHIFT or in DONE:
  - the state returns to IDLE immediately, without waiting for a clock;
  - the chain, prescaler and bit counter clear;
  - ser_out, bit_tick, busy and done all go to 0;
  - no done pulse is produced for the aborted word.
- Reset deasserted: the first accept is possible on the first rising edge with reset_n = 1.
- Reset values: ser_out = 0, bit_tick = 0, busy = 0, done = 0.

## Test plan
All cases use WIDTH = 8, DIV = 4 unless stated.

- MSB first: data_in = 0xC1, msb_first = 1, one-cycle start.
  - ser_out = 1,1,0,0,0,0,0,1, 4 cycles per bit.
  - bit_tick pulses 8 times, 4 cycles apart.
  - done = 1 exactly in cycle 33 after E0; busy is high for 33 cycles.
- LSB first: data_in = 0xC1, msb_first = 0.
  - ser_out = 1,0,0,0,0,0,1,1.
  - Changing data_in and msb_first mid-word has no effect.
- Start while busy: hold start = 1 continuously with data 0xFF, then 0x00.
  - The first word completes with no restart.
  - The second word is accepted on the edge after DONE, with one IDLE cycle between the two busy windows.
- Reset mid-word: assert reset_n = 0 during the 3rd bit period, between clock edges.
  - All outputs are 0 immediately, with no done pulse.
  - After release, a new start with 0x81 serializes correctly.
- DIV = 1, WIDTH = 4: data_in = 0xA, msb_first = 1.
  - ser_out = 1,0,1,0 on consecutive cycles.
  - bit_tick is high for 4 consecutive cycles.
  - done is in cycle 5.
- Idle behaviour: start held low for 20 cycles after reset.
  - ser_out, bit_tick, busy and done remain 0 throughout.
